max_pool_stage: RTL and testbench

Layer-1 stage of the image convolution circuit: reads the 64×64 layer-0 feature map (convolution + ReLU results) from the shared result memory and computes the 2×2, stride-2 max-pool. Writes the 32×32 result back to the layer-1 region of the same memory. Runs after the convolution stage finishes layer 0, launched by a one-cycle `start`, and reports completion with a one-cycle `done`.

---
 rtl/max_pool_stage_pkg.sv | 24 ++
 rtl/max_pool_stage_pool_addr_gen.sv | 61 ++++++
 rtl/max_pool_stage.sv | 153 +++++++++++++++
 tb/tb_max_pool_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/max_pool_stage_pkg.sv
// Shared definitions for the max-pool stage and its neighbours on the result memory.
// The pixel typedef is the 4.16 layout that the convolution stage also uses.
package max_pool_stage_pkg;

  localparam int IMG_W_DEF  = 64;
  localparam int DATA_W_DEF = 20;
  localparam int ADDR_W_DEF = 12;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  // signed 4.16 fixed point
  typedef logic signed [DATA_W_DEF-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LAST,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/max_pool_stage_pool_addr_gen.sv
// Row/column/window counters for the 2x2 pool walk.
// Addresses are produced from the next counter values so the top can register them.
module pool_addr_gen #(
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              k_adv,
  input  logic              pix_adv,
  output logic [1:0]        k_cur,
  output logic              k_last,
  output logic              pix_last,
  output logic [ADDR_W-1:0] rd_addr_nxt,
  output logic [ADDR_W-1:0] wr_addr_nxt
);

  localparam int CW = $clog2(IMG_W / 2);

  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [1:0]    k_q, k_d;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    if (clr) begin
      r_d = '0;
      c_d = '0;
      k_d = '0;
    end else begin
      if (k_adv) k_d = k_q + 2'd1;
      if (pix_adv) begin
        c_d = c_q + CW'(1);
        if (c_q == '1) r_d = r_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
    end
  end

  // Power-of-two width makes the window address a plain bit concatenation.
  assign rd_addr_nxt = ADDR_W'({r_d, k_d[1], c_d, k_d[0]});
  assign wr_addr_nxt = ADDR_W'({r_d, c_d});
  assign k_cur       = k_q;
  assign k_last      = (k_q == 2'd3);
  assign pix_last    = (r_q == '1) && (c_q == '1);

endmodule

// File: rtl/max_pool_stage.sv
// 2x2 stride-2 max-pool over the layer-0 map, writing the result to layer 1.
// Outputs are registered from the next-state decode so they line up with the state.
module max_pool_stage
  import max_pool_stage_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] m_q, m_d;
  logic [1:0]        k_cur;
  logic              k_last, pix_last;
  logic [ADDR_W-1:0] rd_addr_nxt, wr_addr_nxt;
  logic              ag_clr, ag_k_adv, ag_pix_adv;

  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              crd_d, crd_q;
  logic              cwr_d, cwr_q;
  logic [2:0]        csel_d, csel_q;
  logic [ADDR_W-1:0] caddr_rd_d, caddr_rd_q;
  logic [ADDR_W-1:0] caddr_wr_d, caddr_wr_q;
  logic [DATA_W-1:0] cdata_wr_d, cdata_wr_q;

  assign ag_clr     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ag_k_adv   = (state_q == ST_READ);
  assign ag_pix_adv = (state_q == ST_WRITE);

  pool_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clr         (ag_clr),
    .k_adv       (ag_k_adv),
    .pix_adv     (ag_pix_adv),
    .k_cur       (k_cur),
    .k_last      (k_last),
    .pix_last    (pix_last),
    .rd_addr_nxt (rd_addr_nxt),
    .wr_addr_nxt (wr_addr_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (k_last) state_d = ST_LAST;
      ST_LAST:  state_d = ST_WRITE;
      ST_WRITE: state_d = pix_last ? ST_DONE : ST_READ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read data lags its request by one cycle: sample k-1 arrives while k is issued.
  always_comb begin
    m_d = m_q;
    if (state_q == ST_READ && k_cur == 2'd1) begin
      m_d = cdata_rd;
    end else if ((state_q == ST_READ && k_cur != 2'd0) || state_q == ST_LAST) begin
      if ($signed(cdata_rd) > $signed(m_q)) m_d = cdata_rd;
    end
  end

  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    csel_d     = CSEL_NONE;
    caddr_rd_d = '0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;
    case (state_d)
      ST_READ: begin
        busy_d     = 1'b1;
        crd_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_rd_d = rd_addr_nxt;
      end
      ST_LAST: begin
        busy_d = 1'b1;
        csel_d = CSEL_L0;
      end
      ST_WRITE: begin
        busy_d     = 1'b1;
        cwr_d      = 1'b1;
        csel_d     = CSEL_L1;
        caddr_wr_d = wr_addr_nxt;
        cdata_wr_d = m_d;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= CSEL_NONE;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      m_q        <= m_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign cwr      = cwr_q;
  assign csel     = csel_q;
  assign caddr_rd = caddr_rd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_max_pool_stage.sv
// Bench for max_pool_stage: layer-0 memory model, expected-write scoreboard and bus monitor.
// Map 1 is a ramp with signed-compare windows at pixels 0..2; map 2 is a ramp with a tie window at pixel 0.
module tb_max_pool_stage;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;
  logic [2:0]  csel;

  max_pool_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  typedef struct {
    int          addr;
    logic [19:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [19:0] l0 [0:4095];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    cdata_rd <= crd ? l0[caddr_rd] : 20'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [19:0] exp_val(input int map_id, input int i);
    int r, c;
    r = i / 32;
    c = i % 32;
    if (map_id == 1 && i == 0) return 20'h7FFFF;
    if (map_id == 1 && i == 1) return 20'hFFFFF;
    if (map_id == 1 && i == 2) return 20'h0A98E;
    if (map_id == 2 && i == 0) return 20'h0A98E;
    return 20'((2 * r + 1) * 64 + 2 * c + 1);
  endfunction

  task automatic load_map(input int map_id);
    for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
    if (map_id == 1) begin
      l0[0]  = 20'hFFFFF; l0[1]  = 20'h00000; l0[64] = 20'h80000; l0[65] = 20'h7FFFF;
      l0[2]  = 20'h80000; l0[3]  = 20'hFFFFF; l0[66] = 20'h80001; l0[67] = 20'hFFFFE;
      l0[4]  = 20'h0A98E; l0[5]  = 20'h0A98E; l0[68] = 20'h0A98E; l0[69] = 20'h0A98E;
    end else begin
      l0[0]  = 20'h0A98E; l0[1]  = 20'h0A98E; l0[64] = 20'h0A98E; l0[65] = 20'h0A98E;
    end
  endtask

  task automatic check_quiet(input string pfx);
    chk({pfx, "_busy"},     32'(busy),     32'd0);
    chk({pfx, "_done"},     32'(done),     32'd0);
    chk({pfx, "_crd"},      32'(crd),      32'd0);
    chk({pfx, "_cwr"},      32'(cwr),      32'd0);
    chk({pfx, "_csel"},     32'(csel),     32'd0);
    chk({pfx, "_caddr_rd"}, 32'(caddr_rd), 32'd0);
    chk({pfx, "_caddr_wr"}, 32'(caddr_wr), 32'd0);
    chk({pfx, "_cdata_wr"}, 32'(cdata_wr), 32'd0);
  endtask

  task automatic wait_cycle(input int n);
    for (int i = 0; i < 20000 && (cyc - t0 + 1) != n; i++) @(negedge clk);
  endtask

  task automatic start_run(input int map_id);
    load_map(map_id);
    for (int i = 0; i < 1024; i++) exp_q.push_back('{addr: i, data: exp_val(map_id, i)});
    done_cnt = 0;
    done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    chk("busy_cycle1", 32'(busy), 32'd1);
    chk("crd_cycle1",  32'(crd),  32'd1);
  endtask

  task automatic finish_run(input string nm, input bit repulse);
    if (repulse) begin
      wait_cycle(3);
      #2 start = 1'b1;
      @(negedge clk);
      #2 start = 1'b0;
      wait_cycle(6145);
      #2 start = 1'b1;
      @(negedge clk);
      #2 start = 1'b0;
    end else begin
      for (int i = 0; i < 8000 && done_cnt == 0; i++) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk({nm, "_done_count"}, 32'(done_cnt),    32'd1);
    chk({nm, "_done_cycle"}, 32'(done_cyc),    32'd6145);
    chk({nm, "_idle_busy"},  32'(busy),        32'd0);
    chk({nm, "_pending"},    32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (crd || cwr) chk("rd_wr_excl", 32'(crd && cwr), 32'd0);
      if (crd) chk("csel_on_rd", 32'(csel), 32'd1);
      if (cwr) chk("csel_on_wr", 32'(csel), 32'd3);
      if (cwr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write addr=%0d data=%h required=none", caddr_wr, cdata_wr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(caddr_wr), 32'(e.addr));
          chk("wr_data", 32'(cdata_wr), 32'(e.data));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0 + 1;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    load_map(1);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("idle");

    start_run(1);
    finish_run("run_a", 1'b1);

    start_run(1);
    finish_run("run_b", 1'b0);

    start_run(1);
    wait_cycle(3000);
    #2 reset = 1'b1;
    #1 check_quiet("mid_reset");
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("cwr_in_reset", 32'(cwr), 32'd0);
    end
    #2 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_done", 32'(done_cnt), 32'd0);

    start_run(2);
    finish_run("run_c", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
